// File: rtl/sine_pkg.sv
// Shared widths, quadrant type and quarter-wave index folding for the sine NCO.
package sine_pkg;

   localparam int unsigned ROM_DEPTH = 64;
   localparam int unsigned ROM_WIDTH = 8;
   localparam int unsigned ADDRW     = $clog2(4 * ROM_DEPTH);
   localparam int unsigned IDXW      = ADDRW - 2;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;

   // Odd quadrants run the quarter table backwards.
   function automatic logic [IDXW-1:0] fold_idx(input quad_t quad, input logic [IDXW-1:0] idx);
      return (quad == Q1 || quad == Q3) ? ~idx : idx;
   endfunction

endpackage

// File: rtl/rom_async.sv
// Asynchronous-read quarter-wave sine magnitude ROM, entry i = round(255*sin((i+0.5)*pi/128)).
// INIT_F names the table; an empty name yields a blank ROM.
module rom_async #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 64,
   parameter string       INIT_F = "sine_table_64x8.mem"
) (
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [WIDTH-1:0]         data
);

   localparam logic [7:0] SINE_Q64 [64] = '{
        8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd41,  8'd47,
        8'd53,  8'd59,  8'd65,  8'd71,  8'd77,  8'd83,  8'd89,  8'd95,
        8'd100, 8'd106, 8'd112, 8'd117, 8'd123, 8'd128, 8'd134, 8'd139,
        8'd144, 8'd149, 8'd154, 8'd159, 8'd164, 8'd169, 8'd174, 8'd178,
        8'd183, 8'd187, 8'd191, 8'd195, 8'd199, 8'd203, 8'd207, 8'd210,
        8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd234,
        8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd249,
        8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255
   };

   if (INIT_F == "") begin : g_blank
      assign data = '0;
   end else begin : g_table
      assign data = WIDTH'(SINE_Q64[6'(addr)]);
   end

endmodule

// File: rtl/sine_nco.sv
// Quarter-wave sine NCO: phase accumulator -> folded ROM address -> signed full-wave sample,
// two-stage pipeline with valid/ready backpressure.
module sine_nco
   import sine_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = sine_pkg::ROM_DEPTH,
   parameter int unsigned ROM_WIDTH = sine_pkg::ROM_WIDTH,
   parameter string       ROM_FILE  = "sine_table_64x8.mem",
   parameter int unsigned PHASE_W   = 16,
   parameter int unsigned ADDRW     = $clog2(4 * ROM_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          inc_we,
   input  logic [PHASE_W-1:0]            inc_in,
   input  logic                          en,
   output logic                          in_ready,
   output logic signed [2*ROM_WIDTH-1:0] o_data,
   output logic                          o_valid,
   input  logic                          o_ready
);

   localparam int unsigned DW    = 2 * ROM_WIDTH;
   localparam int unsigned IDX_W = ADDRW - 2;

   logic [PHASE_W-1:0] acc_q, acc_d;
   logic [PHASE_W-1:0] inc_q, inc_d;
   logic               s1_valid_q, s1_valid_d;
   quad_t              s1_quad_q, s1_quad_d;
   logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
   logic               o_valid_q, o_valid_d;
   logic [DW-1:0]      o_data_q, o_data_d;

   logic               adv;
   logic [ADDRW-1:0]   phase;
   quad_t              quad;
   logic [ROM_WIDTH-1:0] mag;
   logic [DW-1:0]      mag_ext;

   assign in_ready = !(o_valid_q && !o_ready);
   assign adv      = in_ready;
   assign phase    = acc_q[PHASE_W-1 -: ADDRW];
   assign quad     = quad_t'(phase[ADDRW-1 -: 2]);
   assign mag_ext  = DW'(mag);

   rom_async #(
      .WIDTH  (ROM_WIDTH),
      .DEPTH  (ROM_DEPTH),
      .INIT_F (ROM_FILE)
   ) u_rom (
      .addr (s1_idx_q),
      .data (mag)
   );

   // Next state: clear beats everything, otherwise the pipe only moves on adv.
   always_comb begin
      acc_d      = acc_q;
      inc_d      = inc_q;
      s1_valid_d = s1_valid_q;
      s1_quad_d  = s1_quad_q;
      s1_idx_d   = s1_idx_q;
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;

      if (inc_we) begin
         inc_d = inc_in;
      end

      if (clr) begin
         acc_d      = '0;
         s1_valid_d = 1'b0;
         o_valid_d  = 1'b0;
      end else if (adv) begin
         s1_valid_d = en;
         o_valid_d  = s1_valid_q;
         if (en) begin
            s1_quad_d = quad;
            s1_idx_d  = IDX_W'(fold_idx(quad, IDXW'(phase[IDX_W-1:0])));
            acc_d     = acc_q + inc_q;
         end
         if (s1_valid_q) begin
            o_data_d = (s1_quad_q inside {Q2, Q3}) ? -mag_ext : mag_ext;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         inc_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_quad_q  <= Q0;
         s1_idx_q   <= '0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
      end else begin
         acc_q      <= acc_d;
         inc_q      <= inc_d;
         s1_valid_q <= s1_valid_d;
         s1_quad_q  <= s1_quad_d;
         s1_idx_q   <= s1_idx_d;
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;

endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
- Quarter-wave sine numerically controlled oscillator; sits directly upstream of the asynchronous sine ROM (`rom_async`).
- A phase accumulator produces the ROM address; the quadrant is folded onto the 64-entry quarter table.
- The unsigned ROM magnitude is consumed and rebuilt into a full-wave signed sample.
- Output stream uses valid/ready with backpressure.

Parameters:
- ROM_DEPTH, 64, entries in the quarter-wave table (power of 2).
- ROM_WIDTH, 8, unsigned magnitude width of each table entry.
- ROM_FILE, "sine_table_64x8.mem", init file passed to the ROM.
- PHASE_W, 16, accumulator width; must be ≥ ADDRW.
- ADDRW, $clog2(4*ROM_DEPTH), full-wave phase bits taken from the accumulator MSBs (8 by default).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: acc=0, pipeline valids=0 (inc_reg kept)
- inc_we  in  1  load phase increment
- inc_in  in  PHASE_W  phase increment value
- en  in  1  request one sample; accepted only when in_ready=1
- in_ready  out  1  = !(o_valid && !o_ready), combinational
- o_data  out  2*ROM_WIDTH  signed full-wave sample
- o_valid  out  1  o_data valid
- o_ready  in  1  downstream accepts o_data

Behaviour:
- Reset values (rst async, active-high): acc=0, inc_reg=0, s1_valid=0, s1_quad=0, s1_idx=0, o_valid=0, o_data=0.
- adv = in_ready. When adv=0, every register except inc_reg holds its value. en is ignored, and no sample is lost or duplicated.

Stage 1, on adv:
- s1_valid <= en.
- If en: phase = acc[PHASE_W-1 -: ADDRW], quad = phase[ADDRW-1:ADDRW-2], idx = phase[ADDRW-3:0].
- If en: s1_idx <= quad[0] ? ~idx : idx (mirror in Q1/Q3). s1_quad <= quad.
- If en: acc <= acc + inc_reg, modulo 2^PHASE_W with natural wrap and no saturation.

ROM:
- rom_async.addr = s1_idx; the magnitude is available combinationally in the same cycle.

Stage 2, on adv:
- o_valid <= s1_valid.
- If s1_valid: o_data <= s1_quad[1] ? -zext(mag) : zext(mag). zext extends to 2*ROM_WIDTH. Range ±(2^ROM_WIDTH-1).

Latency:
- Exactly 2 clk edges from the en-accepting edge to o_valid=1, with no stall.
- Throughput is 1 sample/cycle.

Handshake:
- A transfer occurs when o_valid && o_ready.
- o_data is stable while o_valid && !o_ready.

inc_we:
- inc_reg <= inc_in on that edge, regardless of adv.
- An acc update on the same edge uses the old inc_reg.

clr:
- Has priority over en and adv, including during a stall.
- o_data holds its value while o_valid drops to 0.
- On the cycle after clr, the first accepted sample uses phase 0.

Simultaneous events:
- clr + inc_we: both take effect.
- rst mid-stall: everything returns to reset values immediately.
- Quadrant boundaries are exact:
  - phase 63 → rom[63]
  - phase 64 → rom[63] (mirrored)
  - phase 127 → rom[0]
  - phase 128 → -rom[0]

Decomposition:
- Package sine_pkg holds:
  - ROM_DEPTH/ROM_WIDTH/ADDRW defaults
  - quad_t enum {Q0, Q1, Q2, Q3}
  - helper function fold_idx(quad, idx)
- Sub-module: existing rom_async instantiated unchanged (WIDTH=ROM_WIDTH, DEPTH=ROM_DEPTH, INIT_F=ROM_FILE). No other sub-module.

Test Plan:
- Quadrant sweep: rst, inc_in=256, en=1, o_ready=1 → samples 0..255 equal rom[i], rom[63-(i-64)], -rom[i-128], -rom[63-(i-192)]. Samples 0, 64, 128, 192 = rom[0], rom[63], -rom[0], -rom[63].
- Wrap: continue above to sample 256 → identical to sample 0. Then inc_in=0xFF00 (−256) → sequence runs in reverse with no glitch at phase 0↔255.
- Backpressure: o_ready=0 for 5 cycles mid-stream with en=1 → in_ready=0, o_data constant. After release, the output sequence has no gaps or repeats versus the unstalled golden model.
- Increment change: inc_we with 512 on the same edge as an accepted en → that sample's successor uses +256. Afterwards the address steps by 2.
- Latency/clear: single en pulse after reset → o_valid exactly 2 edges later, o_data=rom[0]. clr during stall → o_valid=0 next cycle. The next en yields rom[0].
- Async reset mid-operation: assert rst between clock edges during streaming → o_valid, o_data, acc = 0 immediately. After release, the first sample is rom[0] once the increment is reloaded.
